// File: rtl/memory_request_arbiter_pkg.sv
// Shared constants and types for the memory request arbiter.
// The word width stands in for the system-wide TIA word width.
package memory_request_arbiter_pkg;

  localparam int TIA_WORD_WIDTH     = 32;
  localparam int DEFAULT_REQUESTERS = 4;
  localparam int DEFAULT_DEPTH      = 1024;

  // Host read acknowledge phase: idle, or the single cycle ack is shown.
  typedef enum logic {
    ACK_IDLE  = 1'b0,
    ACK_PHASE = 1'b1
  } host_ack_e;

  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1) % modulus;
  endfunction

endpackage

// File: rtl/memory_request_arbiter_round_robin_arbiter.sv
// Combinational round-robin picker: grants the first request at or after pointer.
// The advance input allows a grant at all; the caller owns the pointer register.
module round_robin_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] pointer,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic          any_grant
);

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (advance && !any_grant && request[j] && (j == (int'(pointer) + k) % N)) begin
          grant[j]  = 1'b1;
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/memory_request_arbiter.sv
// Shares one read port and one write port of a RAM among PE requesters and the host.
// state (host read) | meaning
// ACK_IDLE          | host read may be granted when requested
// ACK_PHASE         | host_read_ack shown for one cycle, data on host_read_data
module memory_request_arbiter
  import memory_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = DEFAULT_REQUESTERS,
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int WIDTH          = TIA_WORD_WIDTH,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = $clog2(NUM_REQUESTERS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [NUM_REQUESTERS-1:0]            rd_req_valid,
  output logic [NUM_REQUESTERS-1:0]            rd_req_ready,
  input  logic [NUM_REQUESTERS-1:0][WIDTH-1:0] rd_req_index,
  output logic [NUM_REQUESTERS-1:0]            rd_resp_valid,
  input  logic [NUM_REQUESTERS-1:0]            rd_resp_ready,
  output logic [NUM_REQUESTERS-1:0][WIDTH-1:0] rd_resp_data,
  input  logic [NUM_REQUESTERS-1:0]            wr_req_valid,
  output logic [NUM_REQUESTERS-1:0]            wr_req_ready,
  input  logic [NUM_REQUESTERS-1:0][WIDTH-1:0] wr_req_index,
  input  logic [NUM_REQUESTERS-1:0][WIDTH-1:0] wr_req_data,
  input  logic                                 host_read_req,
  input  logic [WIDTH-1:0]                     host_read_index,
  output logic [WIDTH-1:0]                     host_read_data,
  output logic                                 host_read_ack,
  input  logic                                 host_write_req,
  input  logic [WIDTH-1:0]                     host_write_index,
  input  logic [WIDTH-1:0]                     host_write_data,
  output logic                                 host_write_ack,
  output logic                                 ram_read_enable,
  output logic [IW-1:0]                        ram_read_index,
  input  logic [WIDTH-1:0]                     ram_read_data,
  output logic                                 ram_write_enable,
  output logic [IW-1:0]                        ram_write_index,
  output logic [WIDTH-1:0]                     ram_write_data,
  output logic                                 quiescent
);

  logic                      go;
  logic                      host_rd_grant, host_wr_grant;
  logic [NUM_REQUESTERS-1:0] rd_eligible, rd_grant, wr_grant;
  logic                      rd_any, wr_any;
  logic [PW-1:0]             rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next, rd_id;
  logic                      inflight;
  logic [PW-1:0]             inflight_id;
  logic [NUM_REQUESTERS-1:0] buf_valid, loading, resp_valid;
  logic [NUM_REQUESTERS-1:0][WIDTH-1:0] buf_data;
  host_ack_e                 host_state;
  logic                      unused_index_bits;

  assign go            = enable && !reset;
  assign host_rd_grant = go && host_read_req && (host_state == ACK_IDLE);
  assign host_wr_grant = go && host_write_req;
  assign host_write_ack = host_wr_grant;
  assign host_read_data = ram_read_data;
  assign unused_index_bits = ^{rd_req_index, wr_req_index, host_read_index, host_write_index};

  // The response shows in the cycle the RAM data arrives, then stays buffered until drained.
  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      loading[i]      = inflight && (inflight_id == PW'(i));
      resp_valid[i]   = buf_valid[i] || loading[i];
      rd_eligible[i]  = go && rd_req_valid[i] && (!resp_valid[i] || rd_resp_ready[i]);
      rd_resp_data[i] = loading[i] ? ram_read_data : buf_data[i];
    end
  end

  assign rd_resp_valid = resp_valid;

  round_robin_arbiter #(.N(NUM_REQUESTERS)) u_rd_arb (
    .request   (rd_eligible),
    .pointer   (rd_ptr),
    .advance   (go && !host_rd_grant),
    .grant     (rd_grant),
    .any_grant (rd_any)
  );

  round_robin_arbiter #(.N(NUM_REQUESTERS)) u_wr_arb (
    .request   (wr_req_valid),
    .pointer   (wr_ptr),
    .advance   (go && !host_wr_grant),
    .grant     (wr_grant),
    .any_grant (wr_any)
  );

  assign rd_req_ready     = rd_grant;
  assign wr_req_ready     = wr_grant;
  assign ram_read_enable  = host_rd_grant || rd_any;
  assign ram_write_enable = host_wr_grant || wr_any;

  always_comb begin
    ram_read_index  = host_read_index[IW-1:0];
    ram_write_index = host_write_index[IW-1:0];
    ram_write_data  = host_write_data;
    rd_ptr_next     = rd_ptr;
    wr_ptr_next     = wr_ptr;
    rd_id           = '0;
    for (int j = 0; j < NUM_REQUESTERS; j++) begin
      if (rd_grant[j]) begin
        ram_read_index = rd_req_index[j][IW-1:0];
        rd_ptr_next    = PW'(wrap_inc(j, NUM_REQUESTERS));
        rd_id          = PW'(j);
      end
      if (wr_grant[j]) begin
        ram_write_index = wr_req_index[j][IW-1:0];
        ram_write_data  = wr_req_data[j];
        wr_ptr_next     = PW'(wrap_inc(j, NUM_REQUESTERS));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_id   <= '0;
      buf_valid     <= '0;
      host_state    <= ACK_IDLE;
      host_read_ack <= 1'b0;
      quiescent     <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr_next;
      wr_ptr   <= wr_ptr_next;
      inflight <= rd_any;
      if (rd_any) inflight_id <= rd_id;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        buf_valid[i] <= resp_valid[i] && !rd_resp_ready[i];
        if (loading[i]) buf_data[i] <= ram_read_data;
      end
      if (enable) begin
        host_state    <= host_rd_grant ? ACK_PHASE : ACK_IDLE;
        host_read_ack <= host_rd_grant;
        quiescent     <= !(|rd_req_valid) && !(|wr_req_valid) && !(|buf_valid) && !inflight;
      end
    end
  end

endmodule
